// File: rtl/audio_cfg_ctrl_pkg.sv
// Shared definitions for the audio filter configuration controller:
// word map, sequencer states, mute level and the coefficient bundle.
package audio_cfg_ctrl_pkg;

    localparam logic [3:0] A_RATE_LO = 4'd0;
    localparam logic [3:0] A_RATE_HI = 4'd1;
    localparam logic [3:0] A_CX_LO   = 4'd2;
    localparam logic [3:0] A_CX_MID  = 4'd3;
    localparam logic [3:0] A_CX_HI   = 4'd4;
    localparam logic [3:0] A_CX10    = 4'd5;
    localparam logic [3:0] A_CX2     = 4'd6;
    localparam logic [3:0] A_CY0_LO  = 4'd7;
    localparam logic [3:0] A_CY0_HI  = 4'd8;
    localparam logic [3:0] A_CY1_LO  = 4'd9;
    localparam logic [3:0] A_CY1_HI  = 4'd10;
    localparam logic [3:0] A_CY2_LO  = 4'd11;
    localparam logic [3:0] A_CY2_HI  = 4'd12;
    localparam logic [3:0] A_CTL     = 4'd13;

    localparam logic [4:0] MUTE_LVL = 5'd16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_FADE_OUT,
        S_APPLY,
        S_CTL
    } state_t;

    typedef struct packed {
        logic [31:0] flt_rate;
        logic [39:0] cx;
        logic [7:0]  cx0;
        logic [7:0]  cx1;
        logic [7:0]  cx2;
        logic [23:0] cy0;
        logic [23:0] cy1;
        logic [23:0] cy2;
    } coef_t;

    function automatic logic [4:0] att_target(input logic [4:0] t);
        return (t > MUTE_LVL) ? MUTE_LVL : t;
    endfunction

endpackage

// File: rtl/audio_cfg_ctrl_if.sv
// Register-write / commit bus of the audio configuration controller.
// The controller reports its busy status back on the same bus.
interface audio_cfg_ctrl_if;

    logic        wr;
    logic [3:0]  addr;
    logic [15:0] wdata;
    logic        commit;
    logic        busy;

    modport master (
        output wr, addr, wdata, commit,
        input  busy
    );

    modport slave (
        input  wr, addr, wdata, commit,
        output busy
    );

endinterface

// File: rtl/audio_cfg_ctrl_att_ramp.sv
// Attenuation ramp: moves att one step toward the target
// every RAMP_SAMPLES sample strobes, never skipping a level.
module att_ramp
    import audio_cfg_ctrl_pkg::*;
#(
    parameter int unsigned RAMP_SAMPLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sample_ce,
    input  logic       en,
    input  logic       reload,
    input  logic [4:0] target,
    output logic [4:0] att
);

    localparam logic [9:0] LAST = 10'(RAMP_SAMPLES - 1);

    logic [9:0] cnt;
    logic       hold;

    assign hold = reload || !en || (att == target);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            att <= MUTE_LVL;
        end else if (hold) begin
            cnt <= '0;
        end else if (sample_ce) begin
            if (cnt == LAST) begin
                cnt <= '0;
                att <= (att < target) ? att + 5'd1 : att - 5'd1;
            end else begin
                cnt <= cnt + 10'd1;
            end
        end
    end

endmodule

// File: rtl/audio_cfg_ctrl.sv
// Audio filter configuration controller: shadow registers, commit
// sequencer with mute fade around coefficient swaps, and mix update.
module audio_cfg_ctrl
    import audio_cfg_ctrl_pkg::*;
#(
    parameter int unsigned RAMP_SAMPLES = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sample_ce,
    audio_cfg_ctrl_if.slave         bus,
    output logic [31:0]             flt_rate,
    output logic [39:0]             cx,
    output logic [7:0]              cx0,
    output logic [7:0]              cx1,
    output logic [7:0]              cx2,
    output logic [23:0]             cy0,
    output logic [23:0]             cy1,
    output logic [23:0]             cy2,
    output logic [4:0]              att,
    output logic [1:0]              mix,
    output logic                    flt_clr
);

    state_t     state;
    state_t     state_n;
    coef_t      shd;
    coef_t      act;
    logic [4:0] att_t;
    logic [1:0] mix_t;
    logic       dirty;
    logic       ctl_dirty;
    logic       commit_pend;
    logic       att_en;
    logic [4:0] att_tgt;
    logic       wr_coef;
    logic       wr_ctl;

    assign wr_coef = bus.wr && (bus.addr <= A_CY2_HI);
    assign wr_ctl  = bus.wr && (bus.addr == A_CTL);

    always_comb begin
        state_n = state;
        att_en  = 1'b0;
        att_tgt = att_target(att_t);
        unique case (state)
            S_IDLE: begin
                att_en = 1'b1;
                if (bus.commit || commit_pend)
                    state_n = S_WAIT;
            end
            S_WAIT: begin
                if (sample_ce)
                    state_n = dirty ? S_FADE_OUT : S_CTL;
            end
            S_FADE_OUT: begin
                att_en  = 1'b1;
                att_tgt = MUTE_LVL;
                if (att == MUTE_LVL)
                    state_n = S_APPLY;
            end
            S_APPLY: begin
                state_n = S_CTL;
            end
            S_CTL: begin
                att_en = 1'b1;
                if (sample_ce)
                    state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            act         <= '0;
            mix         <= '0;
            dirty       <= 1'b0;
            ctl_dirty   <= 1'b0;
            commit_pend <= 1'b0;
        end else begin
            state <= state_n;
            if (state == S_APPLY)
                act <= shd;
            if (state == S_CTL && sample_ce)
                mix <= mix_t;
            // A write landing in the clearing cycle keeps its flag.
            dirty <= wr_coef || (dirty && state != S_APPLY);
            ctl_dirty <= wr_ctl ||
                (ctl_dirty && !(state == S_CTL && sample_ce));
            if (state == S_IDLE && state_n == S_WAIT)
                commit_pend <= 1'b0;
            else if (bus.commit && state != S_IDLE)
                commit_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shd   <= '0;
            att_t <= '0;
            mix_t <= '0;
        end else if (bus.wr) begin
            case (bus.addr)
                A_RATE_LO: shd.flt_rate[15:0]  <= bus.wdata;
                A_RATE_HI: shd.flt_rate[31:16] <= bus.wdata;
                A_CX_LO:   shd.cx[15:0]        <= bus.wdata;
                A_CX_MID:  shd.cx[31:16]       <= bus.wdata;
                A_CX_HI:   shd.cx[39:32]       <= bus.wdata[7:0];
                A_CX10:    {shd.cx1, shd.cx0}  <= bus.wdata;
                A_CX2:     shd.cx2             <= bus.wdata[7:0];
                A_CY0_LO:  shd.cy0[15:0]       <= bus.wdata;
                A_CY0_HI:  shd.cy0[23:16]      <= bus.wdata[7:0];
                A_CY1_LO:  shd.cy1[15:0]       <= bus.wdata;
                A_CY1_HI:  shd.cy1[23:16]      <= bus.wdata[7:0];
                A_CY2_LO:  shd.cy2[15:0]       <= bus.wdata;
                A_CY2_HI:  shd.cy2[23:16]      <= bus.wdata[7:0];
                A_CTL: begin
                    att_t <= bus.wdata[4:0];
                    mix_t <= bus.wdata[6:5];
                end
                default: ;
            endcase
        end
    end

    att_ramp #(
        .RAMP_SAMPLES(RAMP_SAMPLES)
    ) u_att_ramp (
        .clk       (clk),
        .reset     (reset),
        .sample_ce (sample_ce),
        .en        (att_en),
        .reload    (state_n != state),
        .target    (att_tgt),
        .att       (att)
    );

    assign bus.busy = (state != S_IDLE) || commit_pend;
    assign flt_clr  = (state == S_APPLY);
    assign flt_rate = act.flt_rate;
    assign cx       = act.cx;
    assign cx0      = act.cx0;
    assign cx1      = act.cx1;
    assign cx2      = act.cx2;
    assign cy0      = act.cy0;
    assign cy1      = act.cy1;
    assign cy2      = act.cy2;

endmodule

// File: tb/tb_audio_cfg_ctrl.sv
// Directed bench for audio_cfg_ctrl with RAMP_SAMPLES = 4:
// table-driven coefficient writes plus sequencer corner cases.
module tb_audio_cfg_ctrl;

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] wdata;
    } wr_vec_t;

    typedef struct {
        string       name;
        int          sel;
        logic [39:0] exp;
    } out_vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_ce;
    logic [31:0] flt_rate;
    logic [39:0] cx;
    logic [7:0]  cx0, cx1, cx2;
    logic [23:0] cy0, cy1, cy2;
    logic [4:0]  att;
    logic [1:0]  mix;
    logic        flt_clr;

    audio_cfg_ctrl_if bus();

    audio_cfg_ctrl #(.RAMP_SAMPLES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .sample_ce (sample_ce),
        .bus       (bus),
        .flt_rate  (flt_rate),
        .cx        (cx),
        .cx0       (cx0),
        .cx1       (cx1),
        .cx2       (cx2),
        .cy0       (cy0),
        .cy1       (cy1),
        .cy2       (cy2),
        .att       (att),
        .mix       (mix),
        .flt_clr   (flt_clr)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Observers sampled on the falling edge.
    int          clr_cnt   = 0;
    int          clr_bad   = 0;
    int          early_cnt = 0;
    int          over_cnt  = 0;
    int          rise_cnt  = 0;
    logic [4:0]  lim       = 5'd16;
    logic        watch     = 1'b0;
    logic [31:0] fr_prev   = '0;
    logic        busy_prev = 1'b0;

    always @(negedge clk) begin
        if (flt_clr) begin
            clr_cnt++;
            if (att != 5'd16) clr_bad++;
        end
        if (flt_rate != fr_prev && att != 5'd16) early_cnt++;
        fr_prev = flt_rate;
        if (att > lim) over_cnt++;
        if (watch && bus.busy && !busy_prev) rise_cnt++;
        busy_prev = bus.busy;
    end

    task automatic chk(input string nm, input logic [39:0] got,
                       input logic [39:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        sample_ce = 1'b1;
        tick();
        sample_ce = 1'b0;
        tick();
    endtask

    task automatic wr_word(input logic [3:0] a, input logic [15:0] d,
                           input logic with_commit);
        bus.wr     = 1'b1;
        bus.addr   = a;
        bus.wdata  = d;
        bus.commit = with_commit;
        tick();
        bus.wr     = 1'b0;
        bus.commit = 1'b0;
    endtask

    task automatic do_commit();
        bus.commit = 1'b1;
        tick();
        bus.commit = 1'b0;
    endtask

    function automatic logic [39:0] get_out(input int s);
        case (s)
            0: return 40'(flt_rate);
            1: return cx;
            2: return 40'(cx0);
            3: return 40'(cx1);
            4: return 40'(cx2);
            5: return 40'(cy0);
            6: return 40'(cy1);
            7: return 40'(cy2);
            default: return '0;
        endcase
    endfunction

    wr_vec_t  wv[13];
    out_vec_t ov[8];

    initial begin
        int  base, obase, rbase, k;
        bit  done;

        wv[0]  = '{4'd0,  16'h1234};
        wv[1]  = '{4'd1,  16'hABCD};
        wv[2]  = '{4'd2,  16'h5678};
        wv[3]  = '{4'd3,  16'h9ABC};
        wv[4]  = '{4'd4,  16'hFFDE};
        wv[5]  = '{4'd5,  16'h2211};
        wv[6]  = '{4'd6,  16'hFF33};
        wv[7]  = '{4'd7,  16'h4455};
        wv[8]  = '{4'd8,  16'hFF66};
        wv[9]  = '{4'd9,  16'h7788};
        wv[10] = '{4'd10, 16'hFF99};
        wv[11] = '{4'd11, 16'hAABB};
        wv[12] = '{4'd12, 16'hFFCC};

        ov[0] = '{"flt_rate", 0, 40'hAB_CD12_34};
        ov[1] = '{"cx",       1, 40'hDE_9ABC_5678};
        ov[2] = '{"cx0",      2, 40'h11};
        ov[3] = '{"cx1",      3, 40'h22};
        ov[4] = '{"cx2",      4, 40'h33};
        ov[5] = '{"cy0",      5, 40'h66_4455};
        ov[6] = '{"cy1",      6, 40'h99_7788};
        ov[7] = '{"cy2",      7, 40'hCC_AABB};

        reset      = 1'b1;
        sample_ce  = 1'b0;
        bus.wr     = 1'b0;
        bus.addr   = '0;
        bus.wdata  = '0;
        bus.commit = 1'b0;
        repeat (3) tick();

        chk("rst_att", att, 40'd16);
        chk("rst_busy", bus.busy, 40'd0);
        chk("rst_flt_rate", flt_rate, 40'd0);
        chk("rst_mix", mix, 40'd0);
        chk("rst_flt_clr", flt_clr, 40'd0);

        // Ramp 16 -> 0 after reset, one step per 4 strobes.
        reset = 1'b0;
        tick();
        for (int i = 1; i <= 64; i++) begin
            pulse();
            if (i == 3) chk("ramp_no_early", att, 40'd16);
            if (i % 4 == 0) chk("ramp_down", att, 40'(16 - i / 4));
        end
        chk("ramp_busy", bus.busy, 40'd0);

        // Full coefficient set, committed with fade-out.
        base = clr_cnt;
        for (int i = 0; i < 13; i++)
            wr_word(wv[i].addr, wv[i].wdata, 1'b0);
        chk("shadow_only", flt_rate, 40'd0);
        do_commit();
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            pulse();
            done = !bus.busy && att == 5'd0;
        end
        chk("seq1_done", done, 40'd1);
        chk("seq1_clr_cnt", 40'(clr_cnt - base), 40'd1);
        chk("seq1_clr_att", 40'(clr_bad), 40'd0);
        chk("seq1_early", 40'(early_cnt), 40'd0);
        for (int i = 0; i < 8; i++)
            chk(ov[i].name, get_out(ov[i].sel), ov[i].exp);

        // Control-only commit: no fade, mix update, att -> 5.
        base  = clr_cnt;
        lim   = 5'd5;
        obase = over_cnt;
        wr_word(4'd13, 16'h0045, 1'b0);
        do_commit();
        done = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            pulse();
            done = mix == 2'd2;
        end
        chk("ctl_mix", mix, 40'd2);
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            pulse();
            done = !bus.busy && att == 5'd5;
        end
        chk("ctl_att", att, 40'd5);
        chk("ctl_no_clr", 40'(clr_cnt - base), 40'd0);
        chk("ctl_no_fade", 40'(over_cnt - obase), 40'd0);

        // Commit while fading: queued, busy never drops.
        lim  = 5'd16;
        base = clr_cnt;
        wr_word(4'd0, 16'h0001, 1'b0);
        do_commit();
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            pulse();
            done = att == 5'd6;
        end
        chk("pend_fading", done, 40'd1);
        watch = 1'b1;
        rbase = rise_cnt;
        do_commit();
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            pulse();
            done = clr_cnt != base;
        end
        chk("pend_first_apply", done, 40'd1);
        k = 0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            pulse();
            k++;
            done = !bus.busy;
        end
        watch = 1'b0;
        chk("pend_strobes", 40'(k), 40'd3);
        chk("pend_busy_gap", 40'(rise_cnt - rbase), 40'd0);
        chk("pend_clr_cnt", 40'(clr_cnt - base), 40'd1);
        chk("pend_flt_rate", flt_rate, 40'h0000_ABCD_0001);

        // Write and commit in the same cycle.
        base = clr_cnt;
        wr_word(4'd5, 16'hBEEF, 1'b1);
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            pulse();
            done = !bus.busy && clr_cnt != base;
        end
        chk("same_cyc_done", done, 40'd1);
        chk("same_cyc_cx0", cx0, 40'hEF);
        chk("same_cyc_cx1", cx1, 40'hBE);
        chk("same_cyc_early", 40'(early_cnt), 40'd0);

        // Oversized target saturates at mute.
        obase = over_cnt;
        wr_word(4'd13, 16'h001F, 1'b0);
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            pulse();
            done = att == 5'd16;
        end
        repeat (40) pulse();
        chk("sat_att", att, 40'd16);
        chk("sat_never_over", 40'(over_cnt - obase), 40'd0);
        chk("sat_mix_kept", mix, 40'd2);

        // Reset in the middle of a sequence.
        base = clr_cnt;
        wr_word(4'd0, 16'h5555, 1'b0);
        do_commit();
        tick();
        chk("mid_busy", bus.busy, 40'd1);
        reset = 1'b1;
        #2;
        chk("mid_rst_busy", bus.busy, 40'd0);
        chk("mid_rst_clr", flt_clr, 40'd0);
        chk("mid_rst_rate", flt_rate, 40'd0);
        chk("mid_rst_mix", mix, 40'd0);
        repeat (2) tick();
        reset = 1'b0;
        tick();
        repeat (8) pulse();
        chk("mid_no_clr", 40'(clr_cnt - base), 40'd0);
        chk("mid_idle", bus.busy, 40'd0);
        chk("mid_ramp", att, 40'd14);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/audio_cfg_ctrl.md
AUDIO_CFG_CTRL -- requirements
Module: audio_cfg_ctrl

Interface
REQ-001 Parameter: RAMP_SAMPLES, default 64, number of sample_ce pulses per one attenuation step (range 1..1023).
REQ-002 clk  in  1  system clock.
REQ-003 reset  in  1  asynchronous, active-high.
REQ-004 sample_ce  in  1  one-cycle audio sample strobe.
REQ-005 wr  in  1  one-cycle write strobe for a shadow register word.
REQ-006 addr  in  4  word address.
REQ-007 wdata  in  16  write data.
REQ-008 commit  in  1  one-cycle request to apply the shadow set.
REQ-009 busy  out  1  high whenever state is not IDLE.
REQ-010 flt_rate  out  32  active filter rate.
REQ-011 cx  out  40  active filter gain.
REQ-012 cx0, cx1, cx2  out  8 each  active x coefficients.
REQ-013 cy0, cy1, cy2  out  24 each  active y coefficients.
REQ-014 att  out  5  effective attenuation; bit 4 means mute.
REQ-015 mix  out  2  active stereo mix mode.
REQ-016 flt_clr  out  1  one-cycle pulse that clears the filter state.

Function
REQ-017 Word map:
- 0/1: flt_rate[15:0] / [31:16]
- 2/3: cx[15:0] / [31:16]
- 4: cx[39:32] in wdata[7:0]
- 5: {cx1, cx0}
- 6: cx2 in wdata[7:0]
- 7/8: cy0[15:0] / [23:16]
- 9/10: cy1 low / high
- 11/12: cy2 low / high
- 13: att_t = wdata[4:0], mix_t = wdata[6:5]
- 14, 15: ignored.
REQ-018 A write updates only the shadow register; it updates it on the clock edge where wr is high, in any state.
REQ-019 A write to addresses 0..12 sets flag dirty; a write to 13 sets flag ctl_dirty.
REQ-020 A commit received when state is not IDLE sets commit_pend; it never aborts the running sequence.
REQ-021 States and transitions:
- IDLE: on commit or commit_pend, go to WAIT and clear commit_pend.
- WAIT: on the next sample_ce, go to FADE_OUT if dirty, else go to CTL.
- FADE_OUT: att increments 1 per RAMP_SAMPLES sample_ce; go to APPLY once att = 16.
- APPLY: single cycle; copy all coefficient shadows to active; pulse flt_clr; clear dirty; go to CTL.
- CTL: copy mix_t to mix on the next sample_ce; clear ctl_dirty; return to IDLE.
REQ-022 Attenuation target is min(att_t, 16).
REQ-023 In IDLE and CTL, att moves 1 step toward the target every RAMP_SAMPLES sample_ce; att never skips a value.
REQ-024 In FADE_OUT, att rises toward 16 regardless of att_t.
REQ-025 The att output never exceeds 16 (5'h10).
REQ-026 The ramp counter reloads on every state change and whenever att equals the target.
REQ-027 wr and commit in the same cycle: the write takes effect first, and the commit applies the new value.
REQ-028 Active coefficient outputs change only in APPLY; they are never partially updated.

Reset
REQ-029 On reset, every shadow and active register resets to 0.
REQ-030 On reset: att = 16, att_t = 0, mix = 0, state = IDLE.
REQ-031 On reset: dirty, ctl_dirty, commit_pend, flt_clr and busy reset to 0.
REQ-032 After reset, att ramps from 16 to 0 without a commit.
REQ-033 Reset asserted mid-sequence returns to IDLE immediately, with no flt_clr pulse.

Structure
REQ-034 A shared package holds the word-address constants, the state enumeration and the mute level 16.
REQ-035 One sub-module, att_ramp, holds the step counter and the up/down attenuation register.

Verification
REQ-036 Reset release with RAMP_SAMPLES=4 -> att steps 16 to 0, one step per 4 sample_ce (64 sample_ce total); busy=0.
REQ-037 Write addr 0=0x1234 and addr 1=0xABCD, then commit -> flt_rate stays 0 until att=16, then becomes 0xABCD1234 with one flt_clr pulse; att then ramps back to 0.
REQ-038 Write addr 13=0x0045 only, then commit -> no FADE_OUT and no flt_clr; mix=2 at the next sample_ce; att ramps 0 to 5.
REQ-039 Commit during FADE_OUT -> the first sequence completes, then a second sequence runs with busy continuously high.
REQ-040 Write addr 5 and commit in the same cycle -> cx0/cx1 take the new value.
REQ-041 Write att_t=0x1F -> att saturates at 16 and never reaches 31.
